// File: rtl/onn_scan_loader.sv
// ---------------------------------------------------------------------------
// onn_scan_loader
//
// Scan-path master for the oscillator network's serial initialisation chain.
// On a start request it latches an N-neuron initial-phase vector and
// serialises it MSB first into the head of the daisy-chained neuron scan
// path. While doing so it captures the bits returning from the chain tail,
// which are the chain's previous contents. After the last shift it issues a
// one-cycle load strobe so every neuron adopts its new phase, and then a
// one-cycle done pulse.
//
// Chain picture: neuron 0 sits nearest ser_out, and every neuron shifts from
// its LSB toward its MSB. The whole chain therefore behaves like one L-bit
// left-shifting register whose MSB feeds ser_in. This design needs L >= 2.
//
// Ports:
//   clk       in   system clock, rising edge
//   re        in   synchronous active-low reset
//   start     in   load request, sampled only in IDLE
//   phase_in  in   initial phases, neuron k owns [k*PHASE_W +: PHASE_W]
//   ser_in    in   serial return from the last neuron
//   ser_out   out  serial data to the first neuron
//   shift_en  out  scan shift enable to all neurons
//   load      out  one-cycle strobe: neurons adopt scanned value
//   busy      out  high whenever not in IDLE
//   done      out  one-cycle completion pulse
//   phase_rd  out  previous chain contents, same layout as phase_in
// ---------------------------------------------------------------------------
module onn_scan_loader #(
   parameter int N_NEURONS = 4,
   parameter int PHASE_W   = 4
) (
   input  logic                           clk,
   input  logic                           re,
   input  logic                           start,
   input  logic [N_NEURONS*PHASE_W-1:0]   phase_in,
   input  logic                           ser_in,
   output logic                           ser_out,
   output logic                           shift_en,
   output logic                           load,
   output logic                           busy,
   output logic                           done,
   output logic [N_NEURONS*PHASE_W-1:0]   phase_rd
);

   localparam int L     = N_NEURONS * PHASE_W;
   localparam int CNT_W = $clog2(L + 1);
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(L - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [L-1:0]     tx_q, tx_d;
   logic [L-1:0]     rd_q, rd_d;
   logic             ser_out_q, ser_out_d;
   logic             shift_en_q, shift_en_d;
   logic             load_q, load_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // State and every output live in registers so that nothing reaches the
   // ports combinationally. A low re at a clock edge drops everything back
   // to IDLE with all outputs, the counter, the transmit word and the
   // captured word cleared, which also suppresses any pending load strobe.
   always_ff @(posedge clk) begin
      if (!re) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         tx_q       <= '0;
         rd_q       <= '0;
         ser_out_q  <= 1'b0;
         shift_en_q <= 1'b0;
         load_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tx_q       <= tx_d;
         rd_q       <= rd_d;
         ser_out_q  <= ser_out_d;
         shift_en_q <= shift_en_d;
         load_q     <= load_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Next-state and next-output logic. Because outputs are registered, the
   // value computed here is what the neurons see during the following cycle.
   // Accepting start therefore already presents the first (MSB) bit with
   // shift_en high, so the neurons take it at the very next edge. Each shift
   // edge moves the transmit word up by one and presents its new MSB, while
   // the returning tail bit enters the capture word from the bottom. When
   // the counter shows the final shift, the shift enable drops and the load
   // strobe is raised instead.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tx_d       = tx_q;
      rd_d       = rd_q;
      ser_out_d  = 1'b0;
      shift_en_d = 1'b0;
      load_d     = 1'b0;
      busy_d     = 1'b1;
      done_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               state_d    = SHIFT;
               cnt_d      = '0;
               tx_d       = phase_in;
               ser_out_d  = phase_in[L-1];
               shift_en_d = 1'b1;
               busy_d     = 1'b1;
            end
         end
         SHIFT: begin
            rd_d  = {rd_q[L-2:0], ser_in};
            cnt_d = cnt_q + CNT_W'(1);
            tx_d  = tx_q << 1;
            if (cnt_q == LAST_SHIFT) begin
               state_d = LOAD;
               load_d  = 1'b1;
            end else begin
               ser_out_d  = tx_d[L-1];
               shift_en_d = 1'b1;
            end
         end
         LOAD: begin
            state_d = DONE;
            done_d  = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign ser_out  = ser_out_q;
   assign shift_en = shift_en_q;
   assign load     = load_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign phase_rd = rd_q;

endmodule

// File: tb/tb_onn_scan_loader.sv
// ---------------------------------------------------------------------------
// tb_onn_scan_loader
//
// Bench for onn_scan_loader with default parameters (4 neurons x 4 bits).
// The neuron array is represented by a 16-bit register that shifts left on
// every edge with shift_en high, taking ser_out at the bottom and returning
// its top bit on ser_in. Expected values come from a behavioural view of a
// load: the transmitted stream is the latched word MSB first, the captured
// word is whatever the chain held at start, and the timing follows the
// L shift / load / done cycle sequence.
// ---------------------------------------------------------------------------
module tb_onn_scan_loader;

   localparam int L = 16;

   logic          clk;
   logic          re;
   logic          start;
   logic [L-1:0]  phase_in;
   logic          ser_in;
   logic          ser_out;
   logic          shift_en;
   logic          load;
   logic          busy;
   logic          done;
   logic [L-1:0]  phase_rd;

   logic [L-1:0]  chain;
   logic          chainLoad;
   logic [L-1:0]  chainPreset;

   logic [L-1:0]  expRd;
   logic [L-1:0]  cap;
   int            nChecks;
   int            nFail;

   onn_scan_loader #(.N_NEURONS(4), .PHASE_W(4)) dut (
      .clk      (clk),
      .re       (re),
      .start    (start),
      .phase_in (phase_in),
      .ser_in   (ser_in),
      .ser_out  (ser_out),
      .shift_en (shift_en),
      .load     (load),
      .busy     (busy),
      .done     (done),
      .phase_rd (phase_rd)
   );

   // Free-running clock, 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Neuron chain stand-in: one long left shifter, tail bit returns to DUT.
   always @(posedge clk) begin
      if (chainLoad)
         chain <= chainPreset;
      else if (shift_en)
         chain <= {chain[L-2:0], ser_out};
   end
   assign ser_in = chain[L-1];

   // Hard stop in case something keeps the run alive far too long.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
      nChecks++;
      assert (obs === exp)
      else begin
         nFail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full load sequence starting from IDLE. Optional disturbances: a
   // start pulse during shift cycle lockAt, a phase_in change during shift
   // cycle changeAt, a start pulse in the DONE cycle, and a reset during
   // shift cycle resetAt (which ends the sequence early). Without the DONE
   // pulse the task returns right after the done edge, so a following call
   // issues its start at the earliest legal edge.
   task automatic applyStimulus(input logic [L-1:0] pin, input int lockAt, input int changeAt,
                                input logic [L-1:0] changeVal, input bit startInDone,
                                input int resetAt, output logic [L-1:0] captured);
      logic [L-1:0]   prior;
      logic [2*L-1:0] cat;
      prior    = chain;
      cat      = {expRd, prior};
      captured = '0;
      phase_in = pin;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      for (int i = 0; i < L; i++) begin
         checkOutput("shift_en", L'(shift_en), L'(1));
         checkOutput("ser_out", L'(ser_out), L'(pin[L-1-i]));
         checkOutput("busy_shift", L'(busy), L'(1));
         checkOutput("load_shift", L'(load), L'(0));
         checkOutput("done_shift", L'(done), L'(0));
         checkOutput("rd_live", phase_rd, L'(cat >> (L - i)));
         if (i == lockAt)
            start = 1'b1;
         if (i == changeAt)
            phase_in = changeVal;
         if (i == resetAt) begin
            re = 1'b0;
            tick();
            re = 1'b1;
            checkOutput("rst_ser_out", L'(ser_out), L'(0));
            checkOutput("rst_shift_en", L'(shift_en), L'(0));
            checkOutput("rst_load", L'(load), L'(0));
            checkOutput("rst_done", L'(done), L'(0));
            checkOutput("rst_busy", L'(busy), L'(0));
            checkOutput("rst_phase_rd", phase_rd, L'(0));
            expRd = '0;
            for (int k = 0; k < 20; k++) begin
               tick();
               checkOutput("post_rst_idle", L'({load, done, busy, shift_en}), L'(0));
            end
            return;
         end
         tick();
         start = 1'b0;
      end
      expRd = prior;
      checkOutput("load_pulse", L'(load), L'(1));
      checkOutput("shift_off", L'(shift_en), L'(0));
      checkOutput("ser_out_idle", L'(ser_out), L'(0));
      checkOutput("busy_load", L'(busy), L'(1));
      checkOutput("done_load", L'(done), L'(0));
      checkOutput("rd_at_load", phase_rd, prior);
      checkOutput("chain_at_load", chain, pin);
      tick();
      checkOutput("done_pulse", L'(done), L'(1));
      checkOutput("load_once", L'(load), L'(0));
      checkOutput("busy_done", L'(busy), L'(1));
      checkOutput("rd_at_done", phase_rd, prior);
      captured = phase_rd;
      if (startInDone)
         start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("idle_after", L'({load, done, busy, shift_en, ser_out}), L'(0));
      checkOutput("rd_hold", phase_rd, prior);
      if (startInDone) begin
         tick();
         checkOutput("no_requeue", L'({load, done, busy, shift_en}), L'(0));
      end
   endtask

   // Directed scenarios first, then randomized loads with random lockout,
   // input-change and occasional reset disturbances.
   initial begin
      logic [L-1:0] rv;
      logic [L-1:0] cv;
      int           lk;
      int           ch;
      int           rs;
      nChecks     = 0;
      nFail       = 0;
      expRd       = '0;
      re          = 1'b0;
      start       = 1'b0;
      phase_in    = '0;
      chainLoad   = 1'b1;
      chainPreset = 16'h1234;
      tick();
      tick();
      chainLoad = 1'b0;
      checkOutput("reset_outputs", L'({ser_out, shift_en, load, done, busy}), L'(0));
      checkOutput("reset_phase_rd", phase_rd, L'(0));
      re = 1'b1;
      start = 1'b0;
      tick();
      checkOutput("idle_outputs", L'({ser_out, shift_en, load, done, busy}), L'(0));

      $display("[TB] basic load with lockout pulses");
      applyStimulus(16'hA5C3, 5, -1, '0, 1'b1, -1, cap);
      checkOutput("basic_rd", cap, 16'h1234);
      checkOutput("neuron3", L'(chain[15:12]), L'(4'hA));
      checkOutput("neuron0", L'(chain[3:0]), L'(4'h3));

      $display("[TB] restart at earliest edge and input hold");
      applyStimulus(16'h5A3C, -1, -1, '0, 1'b0, -1, cap);
      checkOutput("second_rd", cap, 16'hA5C3);
      applyStimulus(16'hA5C3, -1, 3, 16'hFFFF, 1'b0, -1, cap);
      checkOutput("hold_rd", cap, 16'h5A3C);

      $display("[TB] reset during shift");
      applyStimulus(16'h1357, -1, -1, '0, 1'b0, 7, cap);
      applyStimulus(16'h2468, -1, -1, '0, 1'b0, -1, cap);

      $display("[TB] back-to-back loads");
      applyStimulus(16'h0F0F, -1, -1, '0, 1'b0, -1, cap);
      applyStimulus(16'hF0F0, -1, -1, '0, 1'b0, -1, cap);
      checkOutput("b2b_rd", cap, 16'h0F0F);

      $display("[TB] randomized loads");
      for (int it = 0; it < 8; it++) begin
         rv = 16'($urandom);
         cv = 16'($urandom);
         lk = $urandom_range(0, L - 1);
         ch = $urandom_range(0, L - 1);
         rs = (it == 4) ? $urandom_range(0, L - 1) : -1;
         applyStimulus(rv, lk, ch, cv, 1'($urandom_range(0, 1)), rs, cap);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/onn_scan_loader.md
# onn_scan_loader

Scan-path master for the oscillator network's serial initialisation chain. On a start request it serialises an N-neuron initial-phase vector into the head of the daisy-chained neuron `ser_state_in` path. At the same time it captures the bits returning from the tail `ser_state_out`, which are the chain's previous contents. It then issues a one-cycle load strobe so every neuron adopts its new initial phase. It sits between the host/configuration logic and the neuron array, and is the transmitting end of the per-neuron serial state input.

## Interface
- `N_NEURONS`, default 4: number of neurons in the scan chain.
- `PHASE_W`, default 4: phase word width per neuron, in bits.
- `clk` in 1: system clock; all state changes on its rising edge.
- `re` in 1: reset, synchronous, active-low.
- `start` in 1: request a load; sampled only in IDLE.
- `phase_in` in N_NEURONS*PHASE_W: initial phases; neuron k owns `phase_in[k*PHASE_W +: PHASE_W]`.
- `ser_in` in 1: serial return from the last neuron's `ser_state_out`.
- `ser_out` out 1: serial data to the first neuron's `ser_state_in`.
- `shift_en` out 1: scan shift enable to all neurons; each neuron shifts one bit on a `clk` edge where this is high.
- `load` out 1: one-cycle strobe; neurons transfer scanned value into the phase register.
- `busy` out 1: high whenever not in IDLE.
- `done` out 1: one-cycle completion pulse.
- `phase_rd` out N_NEURONS*PHASE_W: previous chain contents, in the same layout as `phase_in`.

## Operation
- Define L = N_NEURONS*PHASE_W. The bit counter is clog2(L+1) bits wide, unsigned.
- States and transitions:
  - IDLE to SHIFT when `start` is sampled high.
  - SHIFT to LOAD after exactly L shift cycles.
  - LOAD to DONE unconditionally.
  - DONE to IDLE unconditionally.
- On leaving IDLE, `phase_in` is latched into an internal L-bit transmit register. Later changes to `phase_in` have no effect on the load in progress.
- Transmit order is MSB first: shift cycle i (i = 0..L-1) drives `ser_out` = latched bit [L-1-i].
- Chain convention: each neuron shifts from LSB toward MSB, and neuron 0 is nearest `ser_out`.
  - After L shifts, neuron k holds `phase_in[k*PHASE_W +: PHASE_W]`.
- Capture:
  - On each shift edge, `ser_in` is shifted into the LSB of the capture register, which shifts left.
  - After L shifts, `phase_rd` equals the chain's prior contents, in `phase_in` layout.
  - `phase_rd` holds that value until the next SHIFT begins. It is updated live during SHIFT.
- `start` is ignored in SHIFT, LOAD and DONE; there is no queuing.
- Outputs outside SHIFT:
  - `ser_out` = 0.
  - `shift_en` = 0.
- Reset, including mid-operation, when `re` is sampled low:
  - State returns to IDLE.
  - `ser_out`, `shift_en`, `load`, `done` and `busy` go to 0.
  - The counter, transmit register and `phase_rd` go to all zeros.
  - No partial `load` is issued.

## Timing
- Let E0 be the edge at which `start` is sampled high in IDLE.
- `busy` is high from just after E0 up to and including the DONE cycle.
- `shift_en` is high for exactly L consecutive cycles, sampled by the neurons at edges E1..EL. `ser_out` is stable for the whole cycle in which it is sampled.
- `load` is high for one cycle and is sampled at edge E(L+1).
- `done` is high for one cycle and is sampled at edge E(L+2). `busy` falls after that edge.
- Total latency from `start` to `done` is L+2 cycles. The earliest next accepted `start` is at edge E(L+3).
- `phase_rd` is final after edge EL, so it is valid when `load` is high and stays valid through `done`.
- All outputs are registered and have no combinational path from inputs.

## Test plan
- **Basic load.** N=4, W=4, `phase_in`=16'hA5C3, chain modelled as a 16-bit loopback shift register preloaded with 16'h1234.
  - `ser_out` sequence is 1010_0101_1100_0011.
  - `phase_rd`=16'h1234 at `done`.
  - Model contents are 16'hA5C3 at `load`; neuron 3 holds 4'hA and neuron 0 holds 4'h3.
- **Cycle count.** Pulse `start` once.
  - `shift_en` is high for exactly 16 cycles, then `load` for 1 cycle, then `done` for 1 cycle.
  - `done` is sampled 18 edges after E0.
- **Busy lockout.** Pulse `start` again at shift cycle 5 and during the DONE cycle.
  - Only one load sequence occurs, and the transmitted bits are unchanged.
  - `start` at E19 begins a new sequence.
- **Input hold.** Change `phase_in` to 16'hFFFF at shift cycle 3.
  - The transmitted stream still equals 16'hA5C3.
- **Reset mid-shift.** Drive `re`=0 at shift cycle 7.
  - At the next edge: state is IDLE, all outputs are 0, `phase_rd`=0, and no `load` pulse occurs.
  - After reset is released, a new `start` completes a normal 18-cycle sequence.
- **Back-to-back.** Load 16'h0F0F, then 16'hF0F0.
  - The second `phase_rd` equals 16'h0F0F.
